// File: rtl/bram_manager_pkg.sv
// Shared types for the BRAM matrix storage clients.
//   - rc_state_e    : read-client FSM state encoding
//   - dim_t         : 8-bit matrix dimension
//   - count_t       : 16-bit element count (rows x cols)
//   - dim_product() : element count of a rows x cols matrix
package bram_manager_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ID_WIDTH   = 3;

  typedef logic [7:0]  dim_t;
  typedef logic [15:0] count_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_META = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_DATA = 3'd4,
    ST_WAIT_DONE = 3'd5
  } rc_state_e;

  // 255*255 fits in 16 bits, so no overflow handling is needed.
  function automatic count_t dim_product(input dim_t a, input dim_t b);
    return count_t'(a) * count_t'(b);
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major element position tracker for one matrix transfer.
//   clk, rst : clock, async active-high reset
//   clear    : restart at element 0 (row 0, col 0)
//   step     : advance by one element
//   cols     : column count of the current matrix
//   total    : element count of the current matrix
//   row, col : position of the next element to be delivered
//   is_last  : next element is the final one
module matrix_index_counter
  import bram_manager_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   step,
  input  dim_t   cols,
  input  count_t total,
  output dim_t   row,
  output dim_t   col,
  output logic   is_last
);

  count_t count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row   <= '0;
      col   <= '0;
      count <= '0;
    end else if (clear) begin
      row   <= '0;
      col   <= '0;
      count <= '0;
    end else if (step) begin
      count <= count + 16'd1;
      if (col == cols - 8'd1) begin
        col <= '0;
        row <= row + 8'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  assign is_last = (count == total - 16'd1);

endmodule

// File: rtl/matrix_read_client.sv
// Read initiator for matrix_storage_manager. On start it requests one slot,
// captures the metadata and pulls the elements one at a time, streaming them
// out row-major on a valid/ready port with row/col tags and a last flag.
//   start/matrix_id             : command (sampled in IDLE only)
//   busy/done/error             : status; error pulses with done on timeout
//   meta_valid/meta_*           : captured metadata, held until next capture
//   read_req/read_matrix_id     : slot request to the storage manager
//   reader_ready, read_meta_valid, read_rows/cols/matrix_name : storage side
//   read_data_req/read_data_valid/read_data_out : element fetch handshake
//   read_done                   : storage side end-of-matrix
//   m_valid/m_ready/m_data/m_row/m_col/m_last : output element stream
module matrix_read_client
  import bram_manager_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ID_WIDTH       = DEFAULT_ID_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ID_WIDTH-1:0]   matrix_id,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  meta_valid,
  output logic [7:0]            meta_rows,
  output logic [7:0]            meta_cols,
  output logic [63:0]           meta_name,
  output logic                  read_req,
  output logic [ID_WIDTH-1:0]   read_matrix_id,
  input  logic                  reader_ready,
  input  logic                  read_meta_valid,
  input  logic                  read_done,
  input  logic                  read_data_valid,
  input  logic [7:0]            read_rows,
  input  logic [7:0]            read_cols,
  input  logic [63:0]           read_matrix_name,
  input  logic [DATA_WIDTH-1:0] read_data_out,
  output logic                  read_data_req,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [7:0]            m_row,
  output logic [7:0]            m_col,
  output logic                  m_last
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  rc_state_e     state, state_n;
  count_t        total;
  count_t        meta_total;
  logic          done_seen;
  logic [TW-1:0] tcnt;
  logic          timed, timeout, abort, pop;
  dim_t          idx_row, idx_col;
  logic          idx_last, idx_clear, idx_step;

  assign pop        = m_valid && m_ready;
  assign meta_total = dim_product(read_rows, read_cols);
  assign timed      = (state == ST_WAIT_META) || (state == ST_WAIT_DATA) ||
                      (state == ST_WAIT_DONE);
  assign timeout    = timed && (tcnt == TLIM);
  assign idx_clear  = (state == ST_IDLE) && start;
  assign idx_step   = (state == ST_WAIT_DATA) && read_data_valid;

  matrix_index_counter u_idx (
    .clk     (clk),
    .rst     (rst),
    .clear   (idx_clear),
    .step    (idx_step),
    .cols    (meta_cols),
    .total   (total),
    .row     (idx_row),
    .col     (idx_col),
    .is_last (idx_last)
  );

  // A storage response in the same cycle as the timeout wins; abort only
  // when the state is otherwise stuck.
  always_comb begin
    state_n = state;
    abort   = 1'b0;
    case (state)
      // ARM is passed through on the start edge when the reader is already
      // ready, so the request lands in the cycle right after start.
      ST_IDLE: if (start) state_n = reader_ready ? ST_WAIT_META : ST_ARM;
      ST_ARM:  if (reader_ready) state_n = ST_WAIT_META;
      ST_WAIT_META: begin
        if (read_meta_valid) state_n = (meta_total == '0) ? ST_WAIT_DONE : ST_ISSUE;
        else if (timeout) begin state_n = ST_IDLE; abort = 1'b1; end
      end
      ST_ISSUE: if (!m_valid || pop) state_n = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        if (read_data_valid) state_n = idx_last ? ST_WAIT_DONE : ST_ISSUE;
        else if (timeout) begin state_n = ST_IDLE; abort = 1'b1; end
      end
      ST_WAIT_DONE: begin
        if ((done_seen || read_done) && !m_valid) state_n = ST_IDLE;
        else if (timeout) begin state_n = ST_IDLE; abort = 1'b1; end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      meta_valid     <= 1'b0;
      meta_rows      <= '0;
      meta_cols      <= '0;
      meta_name      <= '0;
      read_req       <= 1'b0;
      read_matrix_id <= '0;
      read_data_req  <= 1'b0;
      m_valid        <= 1'b0;
      m_data         <= '0;
      m_row          <= '0;
      m_col          <= '0;
      m_last         <= 1'b0;
      total          <= '0;
      done_seen      <= 1'b0;
      tcnt           <= '0;
    end else begin
      state         <= state_n;
      read_req      <= 1'b0;
      read_data_req <= 1'b0;
      meta_valid    <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;

      // Restart the timer on every state change.
      if (state_n != state || !timed) tcnt <= '0;
      else                            tcnt <= tcnt + TW'(1);

      if (pop) m_valid <= 1'b0;
      if (read_done && timed) done_seen <= 1'b1;

      case (state)
        ST_IDLE: if (start) begin
          read_matrix_id <= matrix_id;
          busy           <= 1'b1;
          done_seen      <= 1'b0;
          read_req       <= reader_ready;
        end
        ST_ARM: if (reader_ready) read_req <= 1'b1;
        ST_WAIT_META: if (read_meta_valid) begin
          meta_rows  <= read_rows;
          meta_cols  <= read_cols;
          meta_name  <= read_matrix_name;
          meta_valid <= 1'b1;
          total      <= meta_total;
        end
        ST_ISSUE: if (state_n == ST_WAIT_DATA) read_data_req <= 1'b1;
        // The register is known empty here: a request is only issued once
        // the previous element has left.
        ST_WAIT_DATA: if (read_data_valid) begin
          m_valid <= 1'b1;
          m_data  <= read_data_out;
          m_row   <= idx_row;
          m_col   <= idx_col;
          m_last  <= idx_last;
        end
        default: ;
      endcase

      if (state != ST_IDLE && state_n == ST_IDLE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (abort) begin
        error   <= 1'b1;
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_read_client.sv
module tb_matrix_read_client;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int TO = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        last;
  } beat_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [IW-1:0] matrix_id = '0;
  logic busy, done, error, meta_valid, read_req, read_data_req, m_valid, m_last;
  logic [7:0] meta_rows, meta_cols, m_row, m_col;
  logic [63:0] meta_name;
  logic [IW-1:0] read_matrix_id;
  logic reader_ready = 1'b0, read_meta_valid = 1'b0, read_done = 1'b0, read_data_valid = 1'b0;
  logic [7:0] read_rows = '0, read_cols = '0;
  logic [63:0] read_matrix_name = '0;
  logic [DW-1:0] read_data_out = '0, m_data;
  logic m_ready = 1'b0;

  matrix_read_client #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .matrix_id(matrix_id),
    .busy(busy), .done(done), .error(error),
    .meta_valid(meta_valid), .meta_rows(meta_rows), .meta_cols(meta_cols), .meta_name(meta_name),
    .read_req(read_req), .read_matrix_id(read_matrix_id), .reader_ready(reader_ready),
    .read_meta_valid(read_meta_valid), .read_done(read_done), .read_data_valid(read_data_valid),
    .read_rows(read_rows), .read_cols(read_cols), .read_matrix_name(read_matrix_name),
    .read_data_out(read_data_out), .read_data_req(read_data_req),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row), .m_col(m_col),
    .m_last(m_last)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, rdone_cyc = -1, dreq_cyc = -1;
  int rreq_cnt = 0, dreq_cnt = 0, load_cnt = 0, done_cnt = 0, err_cnt = 0, hs_cnt = 0;
  int cur_slot = 0;
  bit mute = 0, bp_mode = 0;
  logic ready_level = 1'b0;

  // Storage contents
  logic [31:0] mem_data [8][64];
  int          mem_rows [8];
  int          mem_cols [8];
  logic [63:0] mem_name [8];

  beat_t exp_q[$];
  beat_t e_beat;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected element stream from the stored matrix, row-major.
  task automatic build_model(input int s);
    exp_q.delete();
    for (int r = 0; r < mem_rows[s]; r++)
      for (int c = 0; c < mem_cols[s]; c++) begin
        beat_t b;
        b.data = mem_data[s][r*mem_cols[s]+c];
        b.row  = 8'(r);
        b.col  = 8'(c);
        b.last = (r == mem_rows[s]-1) && (c == mem_cols[s]-1);
        exp_q.push_back(b);
      end
  endtask

  task automatic do_start(input int s);
    @(posedge clk); #1;
    cur_slot  = s;
    build_model(s);
    matrix_id = IW'(s);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int dcyc,
                           output logic derr, output logic dbusy);
    dcyc = -1; derr = 1'b0; dbusy = 1'b1;
    for (int i = 0; i < budget && dcyc < 0; i++) begin
      @(negedge clk);
      if (done) begin dcyc = cyc; derr = error; dbusy = busy; end
    end
    chk({tag, "_done_in_budget"}, 128'(dcyc >= 0), 128'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {busy, done, error, meta_valid, read_req, read_data_req, m_valid, m_last}, 8'h0);
    chk({tag, "_meta"}, {meta_rows, meta_cols, meta_name}, 80'h0);
    chk({tag, "_idx"}, {read_matrix_id, m_row, m_col}, 19'h0);
    chk({tag, "_data"}, m_data, 32'h0);
  endtask

  // Cycle labelling: the label seen at a negedge is the current cycle.
  initial forever begin
    @(posedge clk);
    if (read_done) rdone_cyc = cyc;
    cyc++;
  end

  // Output-side ready pattern.
  int bp_ctr = 0;
  initial forever begin
    @(posedge clk); #1;
    if (bp_mode) begin
      m_ready = (bp_ctr == 0);
      bp_ctr  = (bp_ctr + 1) % 3;
    end else begin
      m_ready = ready_level;
    end
  end

  // Storage-manager responder: answers each request in the following cycle.
  int rsp_slot = 0, rsp_idx = 0;
  bit done_pend = 0;
  initial forever begin
    @(negedge clk);
    read_meta_valid = 1'b0; read_data_valid = 1'b0; read_done = 1'b0;
    if (rst) begin
      rsp_idx = 0; done_pend = 0;
    end else begin
      if (done_pend) begin read_done = 1'b1; done_pend = 0; end
      if (read_req) begin
        rsp_slot = int'(read_matrix_id);
        rsp_idx = 0;
        read_rows = 8'(mem_rows[rsp_slot]);
        read_cols = 8'(mem_cols[rsp_slot]);
        read_matrix_name = mem_name[rsp_slot];
        read_meta_valid = 1'b1;
        if (mem_rows[rsp_slot] * mem_cols[rsp_slot] == 0) done_pend = 1;
      end
      if (read_data_req && !mute) begin
        read_data_out = mem_data[rsp_slot][rsp_idx];
        read_data_valid = 1'b1;
        rsp_idx++;
        if (rsp_idx == mem_rows[rsp_slot] * mem_cols[rsp_slot]) done_pend = 1;
      end
    end
  end

  // Per-cycle compare against the model and protocol rules.
  logic pv = 1'b0, pr = 1'b0;
  beat_t pb;
  int outstanding = 0, last_dreq = -10;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pv = 1'b0; pr = 1'b0; outstanding = 0; last_dreq = -10;
    end else begin
      if (read_req) rreq_cnt++;
      if (done) done_cnt++;
      if (error) begin err_cnt++; outstanding = 0; end
      if (read_data_req) begin
        dreq_cnt++;
        dreq_cyc = cyc;
        chk("one_outstanding", 128'(outstanding), 128'd0);
        chk("dreq_spacing", 128'((cyc - last_dreq) >= 2), 128'd1);
        outstanding++;
        last_dreq = cyc;
      end
      if (m_valid && !(pv && !pr)) begin
        load_cnt++;
        chk("load_has_request", 128'(outstanding), 128'd1);
        outstanding--;
      end
      if (pv && !pr && !error)
        chk("stall_hold", {m_valid, m_data, m_row, m_col, m_last}, {1'b1, pb});
      if (meta_valid) begin
        chk("meta_dims", {meta_rows, meta_cols}, {8'(mem_rows[cur_slot]), 8'(mem_cols[cur_slot])});
        chk("meta_name", meta_name, mem_name[cur_slot]);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got data %0h row %0d col %0d with no beat expected", m_data, m_row, m_col);
        end else begin
          e_beat = exp_q.pop_front();
          chk("beat", {m_data, m_row, m_col, m_last}, e_beat);
        end
        hs_cnt++;
      end
      pv = m_valid; pr = m_ready; pb = {m_data, m_row, m_col, m_last};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1, "watchdog");
  end

  int dc, d0, r0, q0, l0, h0;
  logic de, db;
  initial begin
    for (int s = 0; s < 8; s++) begin
      mem_rows[s] = 0; mem_cols[s] = 0; mem_name[s] = '0;
      for (int i = 0; i < 64; i++) mem_data[s][i] = '0;
    end
    mem_rows[0] = 3; mem_cols[0] = 3; mem_name[0] = "Matrix_A";
    for (int i = 0; i < 9; i++) mem_data[0][i] = 32'(i + 1);
    mem_rows[1] = 2; mem_cols[1] = 4; mem_name[1] = "Matrix_B";
    for (int i = 0; i < 8; i++) mem_data[1][i] = 32'(10 * (i + 1));
    mem_rows[2] = 0; mem_cols[2] = 5; mem_name[2] = "Empty___";
    mem_rows[3] = 2; mem_cols[3] = 2; mem_name[3] = "Matrix_T";
    for (int i = 0; i < 4; i++) mem_data[3][i] = 32'(100 + i);

    // Reset state
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic 3x3 read, always ready
    reader_ready = 1'b1; ready_level = 1'b1;
    d0 = done_cnt;
    do_start(0);
    chk("model_a_size", 128'(exp_q.size()), 128'd9);
    chk("model_a_last", exp_q[8], {32'd9, 8'd2, 8'd2, 1'b1});
    chk("model_a_first", exp_q[0], {32'd1, 8'd0, 8'd0, 1'b0});
    @(negedge clk); chk("basic_req_hi", read_req, 1'b1);
    @(negedge clk); chk("basic_req_pulse", read_req, 1'b0);
    wait_done("basic", 100, dc, de, db);
    chk("basic_err", de, 1'b0);
    chk("basic_busy_at_done", db, 1'b0);
    chk("basic_meta", {meta_rows, meta_cols, meta_name}, {8'd3, 8'd3, "Matrix_A"});
    chk("basic_all_beats", 128'(exp_q.size()), 128'd0);
    repeat (3) @(posedge clk);
    chk("basic_one_done", 128'(done_cnt - d0), 128'd1);

    // Backpressure 2x4, plus a stray start while busy
    bp_mode = 1;
    h0 = hs_cnt;
    do_start(1);
    chk("model_b_mid", exp_q[5], {32'd60, 8'd1, 8'd1, 1'b0});
    for (int i = 0; i < 100 && hs_cnt < h0 + 2; i++) @(posedge clk);
    #1; matrix_id = 3'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done("bp", 200, dc, de, db);
    chk("bp_err", de, 1'b0);
    chk("bp_id_held", read_matrix_id, 3'd1);
    chk("bp_all_beats", 128'(exp_q.size()), 128'd0);
    bp_mode = 0;

    // Late reader_ready
    reader_ready = 1'b0;
    r0 = rreq_cnt;
    do_start(0);
    repeat (20) @(posedge clk);
    #1;
    chk("late_no_req", 128'(rreq_cnt - r0), 128'd0);
    chk("late_busy", busy, 1'b1);
    reader_ready = 1'b1;
    @(negedge clk); chk("late_req_not_yet", read_req, 1'b0);
    @(negedge clk); chk("late_req_hi", read_req, 1'b1);
    @(negedge clk); chk("late_req_pulse", read_req, 1'b0);
    wait_done("late", 100, dc, de, db);
    chk("late_all_beats", 128'(exp_q.size()), 128'd0);
    chk("late_one_req", 128'(rreq_cnt - r0), 128'd1);

    // Empty matrix
    q0 = dreq_cnt; l0 = load_cnt;
    do_start(2);
    chk("model_empty_size", 128'(exp_q.size()), 128'd0);
    wait_done("empty", 100, dc, de, db);
    chk("empty_no_dreq", 128'(dreq_cnt - q0), 128'd0);
    chk("empty_no_mvalid", 128'(load_cnt - l0), 128'd0);
    chk("empty_done_after_rdone", 128'(dc), 128'(rdone_cyc + 1));
    chk("empty_meta", {meta_rows, meta_cols}, {8'd0, 8'd5});
    chk("empty_err", de, 1'b0);

    // Timeout: element never returned
    mute = 1;
    do_start(3);
    wait_done("timeout", 100, dc, de, db);
    chk("to_err", de, 1'b1);
    chk("to_latency", 128'(dc - dreq_cyc), 128'd16);
    chk("to_busy", db, 1'b0);
    chk("to_mvalid", m_valid, 1'b0);
    @(negedge clk);
    chk("to_err_pulse", {error, done}, 2'b00);
    mute = 0;
    do_start(0);
    wait_done("recover", 100, dc, de, db);
    chk("recover_err", de, 1'b0);
    chk("recover_all_beats", 128'(exp_q.size()), 128'd0);

    // Reset in the middle of a transfer
    h0 = hs_cnt;
    do_start(0);
    for (int i = 0; i < 200 && hs_cnt < h0 + 4; i++) @(posedge clk);
    chk("mid_reached_4", 128'(hs_cnt - h0 >= 4), 128'd1);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_start(0);
    wait_done("after_rst", 100, dc, de, db);
    chk("after_rst_err", de, 1'b0);
    chk("after_rst_all_beats", 128'(exp_q.size()), 128'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
